// File: rtl/burst_adapter.sv
// burst_adapter: turns single cache-line read/write requests into fixed-length
// beat bursts toward memory and reassembles read beats into a full line.
module burst_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  // Refuse geometries the power-of-two beat counter cannot address.
  if (((LINE_W % BEAT_W) != 0) || (BEATS < 2) || ((BEATS & (BEATS - 1)) != 0)
      || (ADDR_W <= OFF_W)) begin : g_bad_geometry
    $fatal(1, "burst_adapter: LINE_W/BEAT_W must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CNT_W-1:0]             r_cnt;
  logic [CNT_W-1:0]             w_cnt_nxt;
  logic [ADDR_W-1:0]            r_bmem_addr;
  logic [ADDR_W-1:0]            w_addr_nxt;
  logic [BEATS-1:0][BEAT_W-1:0] r_wbuf;
  logic [BEATS-1:0][BEAT_W-1:0] w_wbuf_nxt;
  logic [BEATS-1:0][BEAT_W-1:0] r_line;
  logic [BEATS-1:0][BEAT_W-1:0] w_line_nxt;
  logic [BEATS-1:0][BEAT_W-1:0] r_resp_rdata;
  logic                         r_req_ready;
  logic                         r_resp_valid;
  logic                         r_bmem_read;
  logic                         r_bmem_write;
  logic [BEAT_W-1:0]            r_bmem_wdata;
  logic                         w_accept;

  // Acceptance uses the registered ready so nothing is taken in the first
  // cycle after reset before ready is visible to the requester.
  assign w_accept = req_valid && r_req_ready;

  // Next-state, beat counter, address latch and buffer updates.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_bmem_addr;
    w_wbuf_nxt  = r_wbuf;
    w_line_nxt  = r_line;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_addr_nxt = req_addr & ~OFF_MASK;
          w_cnt_nxt  = {CNT_W{1'b0}};
          if (req_we) begin
            w_wbuf_nxt  = req_wdata;
            w_state_nxt = WR_DATA;
          end else begin
            w_state_nxt = RD_CMD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          w_state_nxt = RD_DATA;
        end else begin
          w_state_nxt = RD_CMD;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid) begin
          w_line_nxt[r_cnt] = bmem_rdata;
          w_cnt_nxt         = r_cnt + CNT_ONE;
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RD_DATA;
          end
        end else begin
          w_state_nxt = RD_DATA;
        end
      end
      WR_DATA: begin
        if (bmem_ready) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WR_DATA;
          end
        end else begin
          w_state_nxt = WR_DATA;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counter, address and line/write buffers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_bmem_addr <= {ADDR_W{1'b0}};
      r_wbuf      <= {LINE_W{1'b0}};
      r_line      <= {LINE_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bmem_addr <= w_addr_nxt;
      r_wbuf      <= w_wbuf_nxt;
      r_line      <= w_line_nxt;
    end
  end

  // Outputs registered from the next state so they line up with the state
  // they describe; the read line is published only when a read finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_bmem_wdata <= {BEAT_W{1'b0}};
      r_resp_rdata <= {LINE_W{1'b0}};
    end else begin
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == DONE);
      r_bmem_read  <= (w_state_nxt == RD_CMD);
      r_bmem_write <= (w_state_nxt == WR_DATA);
      if (w_state_nxt == WR_DATA) begin
        r_bmem_wdata <= w_wbuf_nxt[w_cnt_nxt];
      end else begin
        r_bmem_wdata <= {BEAT_W{1'b0}};
      end
      if ((w_state_nxt == DONE) && (r_state == RD_DATA)) begin
        r_resp_rdata <= w_line_nxt;
      end else begin
        r_resp_rdata <= r_resp_rdata;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign bmem_addr  = r_bmem_addr;
  assign bmem_read  = r_bmem_read;
  assign bmem_write = r_bmem_write;
  assign bmem_wdata = r_bmem_wdata;

endmodule
